dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Shares the single-port 64x16 data memory between two requesters.
  - Port 0 (core): the processor's lw/sw path.
  - Port 1 (ldr): the program/data loader that initialises and dumps memory around a run.
- Sequences each access through a small FSM.
- Drives the memory strobes and returns read data with a fixed, known latency.
- Sits between the controller/loader and data_memory; replaces the direct mem_read/mem_write drive.

Parameters:
- ADDR_W, 6, data memory address width
- DATA_W, 16, data word width
- FIXED_PRIO, 0, 0 = round-robin between ports; 1 = core always wins ties

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- core_req  in  1  core access request; held until core_gnt seen
- core_we  in  1  1 = write, 0 = read; stable while core_req high
- core_addr  in  ADDR_W  core word address
- core_wdata  in  DATA_W  core write data
- core_gnt  out  1  one-cycle pulse: core request accepted
- core_rvalid  out  1  one-cycle pulse: core_rdata valid
- core_rdata  out  DATA_W  read data for core
- ldr_req, ldr_we, ldr_addr, ldr_wdata  in  1/1/ADDR_W/DATA_W  loader request, same rules as core
- ldr_gnt, ldr_rvalid  out  1/1  loader grant / read-valid pulses
- ldr_rdata  out  DATA_W  read data for loader
- mem_addr  out  ADDR_W  to data_memory addr
- mem_wdata  out  DATA_W  to data_memory write_data
- mem_read  out  1  to data_memory mem_read
- mem_write  out  1  to data_memory mem_write
- mem_rdata  in  DATA_W  from data_memory read_data; valid the cycle after a mem_read cycle
- busy  out  1  high in any state other than IDLE

Behaviour:
- FSM states: IDLE, ACCESS, RESP.

IDLE:
- No request pending: stay in IDLE.
- Any request: pick a winner, latch its we/addr/wdata into internal registers, go to ACCESS.

Arbitration (both requesting in IDLE):
- FIXED_PRIO=1: core wins.
- FIXED_PRIO=0: the port that did not win last time wins.
- The last-winner register updates only on a grant.
- Single requester: it wins regardless of the pointer.

ACCESS (always exactly 1 cycle):
- gnt of the winner = 1; the other gnt = 0.
- mem_addr/mem_wdata driven from the latched registers.
- mem_write = latched we; mem_read = ~latched we.
- Next state: write goes to IDLE; read goes to RESP.

RESP (1 cycle):
- Winner's rvalid = 1.
- Winner's rdata = mem_rdata.
- Next state: IDLE.

Handshake:
- Requester holds req and its fields stable until it samples gnt = 1.
- Requester deasserts req at the edge ending the gnt cycle, unless it issues a new request.
- A req high in IDLE is always treated as a new request.
- Fields sampled after the IDLE edge are ignored; the latched copy is used.

Latency from req first high in IDLE (uncontended):
- gnt: +1 cycle.
- rvalid: +2 cycles.
- Write occupancy: 2 cycles; read occupancy: 3 cycles.

Output quiet values:
- Outside ACCESS: mem_read, mem_write, both gnt = 0.
- Outside RESP: both rvalid = 0.
- Non-winner rdata and all rdata outside RESP are driven to 0.
- mem_addr and mem_wdata hold their last latched value.

Reset (asynchronous, any state including mid-read):
- State -> IDLE.
- All gnt/rvalid/mem_read/mem_write/busy = 0.
- Latched addr/wdata = 0.
- Last-winner = ldr, so core wins the first tie.
- An in-flight read produces no rvalid.

Fairness:
- FIXED_PRIO=0 with both ports continuously requesting: grants strictly alternate.

Decomposition:
- Package tinychip_mem_pkg:
  - DMEM_ADDR_W = 6, DMEM_DATA_W = 16.
  - typedef enum arb_state_t {IDLE, ACCESS, RESP}.
  - typedef enum logic port_id_t {PORT_CORE = 0, PORT_LDR = 1}.
- Sub-module rr_picker2 (combinational): inputs req[1:0], last_winner, fixed_prio; outputs valid, winner.

Test Plan:
- Core write only: core_req=1, we=1, addr=6'h05, wdata=16'hBEEF -> core_gnt at cycle+1 with mem_write=1, mem_addr=5, mem_wdata=BEEF; no rvalid; IDLE at cycle+2.
- Core read after that write: core_req=1, we=0, addr=5 -> core_gnt at +1 with mem_read=1; core_rvalid at +2 with core_rdata=16'hBEEF; ldr_rvalid stays 0.
- Round-robin: FIXED_PRIO=0, both req held continuously (writes) from reset -> grant order core, ldr, core, ldr; each gnt a 1-cycle pulse 2 cycles apart.
- Fixed priority: FIXED_PRIO=1, both requesting for 3 transactions -> core granted all 3 while its req stays high; ldr granted only after core_req drops.
- Reset mid-read: ldr read of addr 6'h3F, assert reset during ACCESS -> no ldr_rvalid; outputs 0 and busy=0 immediately; a later simultaneous request grants core first.
- Latched fields: core read addr=2 granted, then core_addr changed to 7 during ACCESS -> mem_addr stays 2 and core_rdata equals mem[2].

Source files
------------

// File: rtl/tinychip_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module  : tinychip_mem_pkg
// Purpose : Shared types and sizes for the data-memory arbitration path.
//           Provides the data memory geometry, the arbiter state encoding and
//           the requester port identifiers.
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
package tinychip_mem_pkg;

  localparam int DMEM_ADDR_W = 6;
  localparam int DMEM_DATA_W = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } arb_state_t;

  typedef enum logic {
    PORT_CORE = 1'b0,
    PORT_LDR  = 1'b1
  } port_id_t;

endpackage : tinychip_mem_pkg
`default_nettype wire

// File: rtl/dmem_arbiter_rr_picker2.sv
`default_nettype none
// ============================================================================
// Module  : rr_picker2
// Purpose : Two-way combinational winner selection. A lone requester always
//           wins; on a tie either the core wins (fixed priority) or the port
//           that did not win last time wins (round-robin).
// Ports   : req[1:0]     in   request vector, bit 0 = core, bit 1 = loader
//           last_winner  in   port granted most recently
//           fixed_prio   in   1 = core wins ties, 0 = alternate on ties
//           valid        out  at least one request present
//           winner       out  selected port (meaningful when valid)
// Revision: 1.0 - initial release
// ============================================================================
module rr_picker2
  import tinychip_mem_pkg::*;
(
  input  logic [1:0] req,
  input  port_id_t   last_winner,
  input  logic       fixed_prio,
  output logic       valid,
  output port_id_t   winner
);

  always_comb begin
    valid  = |req;
    winner = PORT_CORE;
    case (req)
      2'b01:   winner = PORT_CORE;
      2'b10:   winner = PORT_LDR;
      2'b11: begin
        if (fixed_prio) begin
          winner = PORT_CORE;
        end else begin
          // Tie: the port that lost last time gets its turn.
          winner = (last_winner == PORT_CORE) ? PORT_LDR : PORT_CORE;
        end
      end
      default: winner = PORT_CORE;
    endcase
  end

endmodule : rr_picker2
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : dmem_arbiter
// Purpose : Shares the single-port 64x16 data memory between the core (port 0)
//           and the loader (port 1). Each access runs IDLE -> ACCESS (one
//           cycle, memory strobe + grant) and, for reads, -> RESP (one cycle,
//           read data returned). Request fields are latched on acceptance.
// Ports   : clk, reset                     clock / async active-high reset
//           core_req/we/addr/wdata    in   core request
//           core_gnt, core_rvalid     out  core grant / read-valid pulses
//           core_rdata                out  core read data (0 when not valid)
//           ldr_req/we/addr/wdata     in   loader request
//           ldr_gnt, ldr_rvalid       out  loader grant / read-valid pulses
//           ldr_rdata                 out  loader read data (0 when not valid)
//           mem_addr, mem_wdata       out  to data memory
//           mem_read, mem_write       out  data memory strobes
//           mem_rdata                 in   data memory read data (1-cycle)
//           busy                      out  arbiter not in IDLE
// Revision: 1.0 - initial release
// ============================================================================
module dmem_arbiter
  import tinychip_mem_pkg::*;
#(
  parameter int ADDR_W     = DMEM_ADDR_W,
  parameter int DATA_W     = DMEM_DATA_W,
  parameter int FIXED_PRIO = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              core_req,
  input  logic              core_we,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [DATA_W-1:0] core_wdata,
  output logic              core_gnt,
  output logic              core_rvalid,
  output logic [DATA_W-1:0] core_rdata,
  input  logic              ldr_req,
  input  logic              ldr_we,
  input  logic [ADDR_W-1:0] ldr_addr,
  input  logic [DATA_W-1:0] ldr_wdata,
  output logic              ldr_gnt,
  output logic              ldr_rvalid,
  output logic [DATA_W-1:0] ldr_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_read,
  output logic              mem_write,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam logic FIXED_PRIO_BIT = (FIXED_PRIO != 0);

  arb_state_t        state;
  arb_state_t        state_next;
  port_id_t          sel;          // winner of the access in flight
  port_id_t          last_winner;  // most recently granted port
  logic              lat_we;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_wdata;

  logic              pick_valid;
  port_id_t          pick_winner;

  rr_picker2 u_picker (
    .req         ({ldr_req, core_req}),
    .last_winner (last_winner),
    .fixed_prio  (FIXED_PRIO_BIT),
    .valid       (pick_valid),
    .winner      (pick_winner)
  );

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    state_next = pick_valid ? ACCESS : IDLE;
      ACCESS:  state_next = lat_we ? IDLE : RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Request capture and arbitration history. Fields are taken only on the
  // IDLE edge that accepts a request; later changes on the port are ignored.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sel         <= PORT_CORE;
      last_winner <= PORT_LDR;   // core wins the first tie after reset
      lat_we      <= 1'b0;
      lat_addr    <= '0;
      lat_wdata   <= '0;
    end else begin
      if (state == IDLE && pick_valid) begin
        sel <= pick_winner;
        if (pick_winner == PORT_LDR) begin
          lat_we    <= ldr_we;
          lat_addr  <= ldr_addr;
          lat_wdata <= ldr_wdata;
        end else begin
          lat_we    <= core_we;
          lat_addr  <= core_addr;
          lat_wdata <= core_wdata;
        end
      end
      // History moves only when a grant is actually issued.
      if (state == ACCESS) begin
        last_winner <= sel;
      end
    end
  end

  // Output decode.
  always_comb begin
    core_gnt    = 1'b0;
    ldr_gnt     = 1'b0;
    core_rvalid = 1'b0;
    ldr_rvalid  = 1'b0;
    core_rdata  = '0;
    ldr_rdata   = '0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    mem_addr    = lat_addr;
    mem_wdata   = lat_wdata;
    busy        = (state != IDLE);
    case (state)
      ACCESS: begin
        core_gnt  = (sel == PORT_CORE);
        ldr_gnt   = (sel == PORT_LDR);
        mem_write = lat_we;
        mem_read  = ~lat_we;
      end
      RESP: begin
        if (sel == PORT_LDR) begin
          ldr_rvalid = 1'b1;
          ldr_rdata  = mem_rdata;
        end else begin
          core_rvalid = 1'b1;
          core_rdata  = mem_rdata;
        end
      end
      default: ;
    endcase
  end

endmodule : dmem_arbiter
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_dmem_arbiter
// Purpose : Self-checking bench for dmem_arbiter. Two instances share the
//           request inputs: u_rr (round-robin) and u_fp (fixed priority), each
//           with its own data memory model. Expected grants / read returns are
//           queued per instance with the cycle they must appear in; a monitor
//           compares them at every falling edge.
// Revision: 1.0 - initial release
// ============================================================================
module tb_dmem_arbiter;

  typedef struct {
    bit          rv;    // 0 = grant event, 1 = read-valid event
    bit          port;  // 0 = core, 1 = loader
    int          cyc;
    bit          we;
    logic [5:0]  addr;
    logic [15:0] data;  // write data for grants, read data for rvalid
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        core_req = 1'b0, core_we = 1'b0;
  logic [5:0]  core_addr = '0;
  logic [15:0] core_wdata = '0;
  logic        ldr_req = 1'b0, ldr_we = 1'b0;
  logic [5:0]  ldr_addr = '0;
  logic [15:0] ldr_wdata = '0;

  logic        cg0, cv0, lg0, lv0, mr0, mw0, bz0;
  logic [15:0] crd0, lrd0, mwd0, mrd0;
  logic [5:0]  ma0;
  logic        cg1, cv1, lg1, lv1, mr1, mw1, bz1;
  logic [15:0] crd1, lrd1, mwd1, mrd1;
  logic [5:0]  ma1;

  logic [15:0] mem0 [64];
  logic [15:0] mem1 [64];

  exp_t q0[$];
  exp_t q1[$];
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dmem_arbiter #(.ADDR_W(6), .DATA_W(16), .FIXED_PRIO(0)) u_rr (
    .clk(clk), .reset(reset),
    .core_req(core_req), .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
    .core_gnt(cg0), .core_rvalid(cv0), .core_rdata(crd0),
    .ldr_req(ldr_req), .ldr_we(ldr_we), .ldr_addr(ldr_addr), .ldr_wdata(ldr_wdata),
    .ldr_gnt(lg0), .ldr_rvalid(lv0), .ldr_rdata(lrd0),
    .mem_addr(ma0), .mem_wdata(mwd0), .mem_read(mr0), .mem_write(mw0),
    .mem_rdata(mrd0), .busy(bz0)
  );

  dmem_arbiter #(.ADDR_W(6), .DATA_W(16), .FIXED_PRIO(1)) u_fp (
    .clk(clk), .reset(reset),
    .core_req(core_req), .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
    .core_gnt(cg1), .core_rvalid(cv1), .core_rdata(crd1),
    .ldr_req(ldr_req), .ldr_we(ldr_we), .ldr_addr(ldr_addr), .ldr_wdata(ldr_wdata),
    .ldr_gnt(lg1), .ldr_rvalid(lv1), .ldr_rdata(lrd1),
    .mem_addr(ma1), .mem_wdata(mwd1), .mem_read(mr1), .mem_write(mw1),
    .mem_rdata(mrd1), .busy(bz1)
  );

  // Single-port data memory models: read data valid the cycle after mem_read.
  always @(posedge clk) begin
    if (mw0) mem0[ma0] <= mwd0;
    if (mr0) mrd0 <= mem0[ma0];
    if (mw1) mem1[ma1] <= mwd1;
    if (mr1) mrd1 <= mem1[ma1];
  end

  task automatic mon(input int d, input logic cg, input logic lg, input logic cv, input logic lv,
                     input logic [15:0] crd, input logic [15:0] lrd, input logic mr, input logic mw,
                     input logic [5:0] ma, input logic [15:0] mwd, input logic bz);
    exp_t e;
    bit   ok;
    if (cg || lg || cv || lv) begin
      checks++;
      if (d == 0 ? q0.size() == 0 : q1.size() == 0) begin
        failures++;
        $display("FAIL d%0d unexpected_event: cyc=%0d gnt=%b%b rvalid=%b%b, required no event",
                 d, cyc, lg, cg, lv, cv);
      end else begin
        e = (d == 0) ? q0.pop_front() : q1.pop_front();
        if (cg || lg) begin
          ok = !e.rv && !(cg && lg) && (lg == e.port) && (cyc == e.cyc) && bz &&
               (mw == e.we) && (mr == !e.we) && (ma == e.addr) && (!e.we || mwd == e.data);
          if (!ok) begin
            failures++;
            $display("FAIL d%0d grant: got cyc=%0d gnt(l,c)=%b%b mw=%b mr=%b addr=%h wdata=%h busy=%b, required rv=%0d port=%0d cyc=%0d we=%0d addr=%h wdata=%h",
                     d, cyc, lg, cg, mw, mr, ma, mwd, bz, e.rv, e.port, e.cyc, e.we, e.addr, e.data);
          end
        end else begin
          ok = e.rv && !(cv && lv) && (lv == e.port) && (cyc == e.cyc) && bz && !mr && !mw &&
               (e.port ? (lrd == e.data && crd == 16'h0) : (crd == e.data && lrd == 16'h0));
          if (!ok) begin
            failures++;
            $display("FAIL d%0d rvalid: got cyc=%0d rvalid(l,c)=%b%b rdata(l,c)=%h/%h, required rv=%0d port=%0d cyc=%0d rdata=%h",
                     d, cyc, lv, cv, lrd, crd, e.rv, e.port, e.cyc, e.data);
          end
        end
      end
    end else begin
      checks++;
      if (mr || mw || crd != 16'h0 || lrd != 16'h0) begin
        failures++;
        $display("FAIL d%0d quiet: cyc=%0d mr=%b mw=%b rdata(l,c)=%h/%h, required all 0",
                 d, cyc, mr, mw, lrd, crd);
      end
    end
  endtask

  always @(negedge clk) begin
    mon(0, cg0, lg0, cv0, lv0, crd0, lrd0, mr0, mw0, ma0, mwd0, bz0);
    mon(1, cg1, lg1, cv1, lv1, crd1, lrd1, mr1, mw1, ma1, mwd1, bz1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int d, input bit rv, input bit port, input int c,
                      input bit we, input logic [5:0] a, input logic [15:0] dat);
    exp_t e;
    e.rv = rv; e.port = port; e.cyc = c; e.we = we; e.addr = a; e.data = dat;
    if (d == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  // Uncontended access on one port; same expectations for both instances.
  task automatic access(input bit port, input bit we, input logic [5:0] a,
                        input logic [15:0] wd, input logic [15:0] rd_exp);
    int t;
    t = cyc;
    if (port) begin
      ldr_req = 1'b1; ldr_we = we; ldr_addr = a; ldr_wdata = wd;
    end else begin
      core_req = 1'b1; core_we = we; core_addr = a; core_wdata = wd;
    end
    for (int d = 0; d < 2; d++) begin
      push(d, 1'b0, port, t + 1, we, a, wd);
      if (!we) push(d, 1'b1, port, t + 2, we, a, rd_exp);
    end
    tick();
    if (port) ldr_req = 1'b0; else core_req = 1'b0;
    tick();
    if (!we) tick();
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_busy"},  {30'd0, bz1, bz0}, 32'd0);
    chk({tag, "_gnt"},   {28'd0, cg1, lg1, cg0, lg0}, 32'd0);
    chk({tag, "_rvalid"},{28'd0, cv1, lv1, cv0, lv0}, 32'd0);
    chk({tag, "_strobe"},{28'd0, mr1, mw1, mr0, mw0}, 32'd0);
    chk({tag, "_addr"},  {20'd0, ma1, ma0}, 32'd0);
    chk({tag, "_wdata"}, {mwd1, mwd0}, 32'd0);
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int t;
    repeat (2) tick();
    chk_reset_outputs("reset");
    reset = 1'b0;
    tick();

    // Core write then read-back of the same word.
    access(1'b0, 1'b1, 6'h05, 16'hBEEF, 16'h0);
    access(1'b0, 1'b0, 6'h05, 16'h0, 16'hBEEF);

    // Latched fields: address changes during ACCESS must not leak through.
    access(1'b0, 1'b1, 6'h02, 16'h1234, 16'h0);
    access(1'b0, 1'b1, 6'h07, 16'h7777, 16'h0);
    t = cyc;
    core_req = 1'b1; core_we = 1'b0; core_addr = 6'h02;
    for (int d = 0; d < 2; d++) begin
      push(d, 1'b0, 1'b0, t + 1, 1'b0, 6'h02, 16'h0);
      push(d, 1'b1, 1'b0, t + 2, 1'b0, 6'h02, 16'h1234);
    end
    tick();
    core_addr = 6'h07; core_req = 1'b0;
    tick();
    tick();

    // Loader read aborted by reset during ACCESS: no grant seen, no rvalid.
    ldr_req = 1'b1; ldr_we = 1'b0; ldr_addr = 6'h3F;
    tick();
    #1 reset = 1'b1; ldr_req = 1'b0;
    #1 chk_reset_outputs("midread");
    tick();
    tick();
    reset = 1'b0;
    tick();

    // Both ports requesting writes continuously, fresh from reset.
    t = cyc;
    core_req = 1'b1; core_we = 1'b1; core_addr = 6'h0A; core_wdata = 16'hA0A0;
    ldr_req  = 1'b1; ldr_we  = 1'b1; ldr_addr  = 6'h0B; ldr_wdata  = 16'hB0B0;
    push(0, 1'b0, 1'b0, t + 1, 1'b1, 6'h0A, 16'hA0A0);
    push(0, 1'b0, 1'b1, t + 3, 1'b1, 6'h0B, 16'hB0B0);
    push(0, 1'b0, 1'b0, t + 5, 1'b1, 6'h0A, 16'hA0A0);
    push(0, 1'b0, 1'b1, t + 7, 1'b1, 6'h0B, 16'hB0B0);
    push(0, 1'b0, 1'b1, t + 9, 1'b1, 6'h0B, 16'hB0B0);
    push(1, 1'b0, 1'b0, t + 1, 1'b1, 6'h0A, 16'hA0A0);
    push(1, 1'b0, 1'b0, t + 3, 1'b1, 6'h0A, 16'hA0A0);
    push(1, 1'b0, 1'b0, t + 5, 1'b1, 6'h0A, 16'hA0A0);
    push(1, 1'b0, 1'b0, t + 7, 1'b1, 6'h0A, 16'hA0A0);
    push(1, 1'b0, 1'b1, t + 9, 1'b1, 6'h0B, 16'hB0B0);
    repeat (8) tick();
    core_req = 1'b0;
    tick();
    ldr_req = 1'b0;
    tick();
    tick();

    // Read back through each port.
    access(1'b1, 1'b0, 6'h0B, 16'h0, 16'hB0B0);
    access(1'b0, 1'b0, 6'h0A, 16'h0, 16'hA0A0);
    access(1'b1, 1'b1, 6'h20, 16'h5A5A, 16'h0);
    access(1'b1, 1'b0, 6'h20, 16'h0, 16'h5A5A);

    repeat (3) tick();
    chk("rr_pending_expectations", q0.size(), 32'd0);
    chk("fp_pending_expectations", q1.size(), 32'd0);
    chk("idle_busy", {30'd0, bz1, bz0}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_dmem_arbiter
`default_nettype wire
